// File: rtl/rvfi_commit_fifo.sv
// RVFI commit FIFO: collects up to NrCommitPorts retired instructions per cycle
// and presents them one at a time, each tagged with a 64-bit retire order number.
// A retire group either fits whole or is dropped whole, which sets a sticky overflow flag.
// Admission is checked against the occupancy at the start of the cycle, so a
// dequeue in the same cycle does not make room for that cycle's group.
module rvfi_commit_fifo #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned DEPTH         = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic [NrCommitPorts-1:0]      commit_ack_i,
  input  logic [NrCommitPorts*XLEN-1:0] commit_pc_i,
  input  logic [NrCommitPorts*32-1:0]   commit_insn_i,
  input  logic [NrCommitPorts*5-1:0]    commit_rd_i,
  input  logic [NrCommitPorts*XLEN-1:0] commit_wdata_i,
  input  logic                          ex_valid_i,
  input  logic [XLEN-1:0]               ex_cause_i,
  output logic                          trace_valid_o,
  input  logic                          trace_ready_i,
  output logic [63:0]                   trace_order_o,
  output logic [XLEN-1:0]               trace_pc_o,
  output logic [31:0]                   trace_insn_o,
  output logic [4:0]                    trace_rd_o,
  output logic [XLEN-1:0]               trace_wdata_o,
  output logic                          trace_trap_o,
  output logic [XLEN-1:0]               trace_cause_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Control state
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   order_q, order_d;
  logic          ovf_q, ovf_d;

  // Entry storage, intentionally not reset
  logic [XLEN-1:0] mem_pc_q    [DEPTH];
  logic [31:0]     mem_insn_q  [DEPTH];
  logic [4:0]      mem_rd_q    [DEPTH];
  logic [XLEN-1:0] mem_wdata_q [DEPTH];
  logic [XLEN-1:0] mem_cause_q [DEPTH];
  logic [63:0]     mem_order_q [DEPTH];
  logic [DEPTH-1:0] mem_trap_q;

  logic [CW-1:0] k;
  logic [CW-1:0] off  [NrCommitPorts];
  logic [AW-1:0] widx [NrCommitPorts];
  logic [CW-1:0] free;
  logic          accept, drop, deq;

  // Per-port slot offset within the group (ascending port order) and group size
  always_comb begin
    k = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      off[p]  = k;
      widx[p] = wptr_q + off[p][AW-1:0];
      if (commit_ack_i[p]) k = k + CW'(1);
    end
  end

  assign free   = CW'(DEPTH) - count_q;
  assign accept = (k != '0) && (k <= free);
  assign drop   = (k > free);
  assign deq    = trace_valid_o && trace_ready_i;

  // Next-state for pointers, occupancy, order counter and overflow; clear wins over everything
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    order_d = order_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      order_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (accept) begin
        wptr_d  = wptr_q + k[AW-1:0];
        order_d = order_q + 64'(k);
      end
      if (drop) ovf_d = 1'b1;
      if (deq) rptr_d = rptr_q + AW'(1);
      count_d = count_q + (accept ? k : '0) - CW'(deq);
    end
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      order_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      order_q <= order_d;
      ovf_q   <= ovf_d;
    end
  end

  // Write each acked port of an admitted group into consecutive slots
  always_ff @(posedge clk_i) begin
    if (!clear_i && accept) begin
      for (int p = 0; p < NrCommitPorts; p++) begin
        if (commit_ack_i[p]) begin
          mem_pc_q[widx[p]]    <= commit_pc_i[p*XLEN +: XLEN];
          mem_insn_q[widx[p]]  <= commit_insn_i[p*32 +: 32];
          mem_rd_q[widx[p]]    <= commit_rd_i[p*5 +: 5];
          mem_wdata_q[widx[p]] <= (commit_rd_i[p*5 +: 5] == 5'd0) ? '0
                                  : commit_wdata_i[p*XLEN +: XLEN];
          mem_order_q[widx[p]] <= order_q + 64'(off[p]);
          mem_trap_q[widx[p]]  <= (p == 0) && ex_valid_i;
          mem_cause_q[widx[p]] <= ((p == 0) && ex_valid_i) ? ex_cause_i : '0;
        end
      end
    end
  end

  // Head is read straight from storage and forced to zero when empty
  assign trace_valid_o = (count_q != '0);
  assign trace_order_o = trace_valid_o ? mem_order_q[rptr_q] : '0;
  assign trace_pc_o    = trace_valid_o ? mem_pc_q[rptr_q]    : '0;
  assign trace_insn_o  = trace_valid_o ? mem_insn_q[rptr_q]  : '0;
  assign trace_rd_o    = trace_valid_o ? mem_rd_q[rptr_q]    : '0;
  assign trace_wdata_o = trace_valid_o ? mem_wdata_q[rptr_q] : '0;
  assign trace_trap_o  = trace_valid_o ? mem_trap_q[rptr_q]  : 1'b0;
  assign trace_cause_o = trace_valid_o ? mem_cause_q[rptr_q] : '0;
  assign count_o       = count_q;
  assign overflow_o    = ovf_q;

endmodule
